// File: rtl/alu_mul_sequencer_if.sv
// Bundle between the multiply sequencer, its controller (start/operands/result)
// and the shared ALU (operands, function select and combinational result).
interface alu_mul_sequencer_if;
  logic        start;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic [31:0] alu_out;
  logic [3:0]  flags_out;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_funsel;
  logic        alu_wf;
  logic        busy;
  logic        done;
  logic [31:0] product;

  modport master (
    output start, multiplicand, multiplier, alu_out, flags_out,
    input  alu_a, alu_b, alu_funsel, alu_wf, busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier, alu_out, flags_out,
    output alu_a, alu_b, alu_funsel, alu_wf, busy, done, product
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// 16x16->32 unsigned shift-and-add multiplier that borrows the shared ALU for
// every add and shift instead of owning an adder.
module alu_mul_sequencer #(
  parameter logic [4:0] ADD_FUNSEL  = 5'b10100,
  parameter logic [4:0] LSL_FUNSEL  = 5'b11011,
  parameter logic [4:0] IDLE_FUNSEL = 5'b10000
) (
  input logic                clk_i,
  input logic                rst_ni,
  alu_mul_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] p_q, p_d;
  logic [31:0] m_q, m_d;
  logic [15:0] q_q, q_d;
  logic [31:0] product_q, product_d;

  // Flags are observed by the controller only; they never steer this block.
  logic unused_flags;
  assign unused_flags = ^bus.flags_out;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its peers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      p_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      m_q       <= m_d;
      q_q       <= q_d;
      product_q <= product_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    p_d            = p_q;
    m_d            = m_q;
    q_d            = q_q;
    product_d      = product_q;
    bus.alu_a      = '0;
    bus.alu_b      = '0;
    bus.alu_funsel = IDLE_FUNSEL;
    bus.alu_wf     = 1'b0;
    bus.done       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          m_d     = {16'b0, bus.multiplicand};
          q_d     = bus.multiplier;
          p_d     = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        // Stop as soon as no set multiplier bits remain.
        if (q_q == '0) begin
          product_d = p_q;
          state_d   = S_DONE;
        end else if (q_q[0]) begin
          state_d = S_ADD;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_ADD: begin
        bus.alu_a      = p_q;
        bus.alu_b      = m_q;
        bus.alu_funsel = ADD_FUNSEL;
        bus.alu_wf     = 1'b1;
        p_d            = bus.alu_out;
        state_d        = S_SHIFT;
      end
      S_SHIFT: begin
        bus.alu_a      = m_q;
        bus.alu_funsel = LSL_FUNSEL;
        m_d            = bus.alu_out;
        q_d            = q_q >> 1;
        state_d        = S_CHECK;
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.product = product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: plays controller and ALU, and compares the DUT
// each cycle against a transaction-level model (product, latency, busy/done).
module tb_alu_mul_sequencer;
  localparam logic [4:0] ADD_F  = 5'b10100;
  localparam logic [4:0] LSL_F  = 5'b11011;
  localparam logic [4:0] IDLE_F = 5'b10000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_mul_sequencer_if bus();

  alu_mul_sequencer dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  // Behavioural ALU.
  logic [32:0] alu_sum;
  assign alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
  assign bus.alu_out = (bus.alu_funsel == ADD_F) ? alu_sum[31:0] :
                       (bus.alu_funsel == LSL_F) ? (bus.alu_a << 1) : bus.alu_a;
  assign bus.flags_out = {bus.alu_out == 32'd0,
                          (bus.alu_funsel == ADD_F) ? alu_sum[32] : 1'b0,
                          bus.alu_out[31], 1'b0};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Cycles from the accepting edge to the Done cycle.
  function automatic int lat_of(input logic [15:0] b);
    int lat = 2;
    for (int i = 0; i < 16; i++)
      if ((b >> i) != 16'd0) lat += b[i] ? 3 : 2;
    return lat;
  endfunction

  // Transaction model: m_cyc is the index of the current cycle after acceptance.
  logic        m_active = 1'b0;
  int          m_cyc = 0;
  int          m_lat = 0;
  logic [15:0] m_b = '0;
  logic [31:0] m_pend = '0;
  logic [31:0] m_prod = '0;
  logic        cmp_en = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_cyc    = 0;
      m_prod   = '0;
    end else if (m_active) begin
      if (m_cyc == m_lat) m_active = 1'b0;
      else begin
        m_cyc++;
        if (m_cyc == m_lat) m_prod = m_pend;
      end
    end else if (bus.start) begin
      m_active = 1'b1;
      m_cyc    = 1;
      m_lat    = lat_of(bus.multiplier);
      m_b      = bus.multiplier;
      m_pend   = 32'(bus.multiplicand) * 32'(bus.multiplier);
    end
  end

  int   wf_cnt = 0;
  logic add_seen = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", 32'(bus.busy), 32'(m_active));
      check("done", 32'(bus.done), 32'(m_active && m_cyc == m_lat));
      check("product", bus.product, m_prod);
      if (!m_active || m_cyc == 1 || m_cyc == m_lat) begin
        check("idle_funsel", 32'(bus.alu_funsel), 32'(IDLE_F));
        check("idle_wf", 32'(bus.alu_wf), 32'd0);
      end
      if (!m_active) begin
        check("idle_a", bus.alu_a, 32'd0);
        check("idle_b", bus.alu_b, 32'd0);
      end else begin
        if (m_cyc == 1) begin
          wf_cnt   = 0;
          add_seen = 1'b0;
        end
        wf_cnt += int'(bus.alu_wf);
        if (bus.alu_funsel == ADD_F) add_seen = 1'b1;
        if (m_cyc == m_lat) begin
          check("wf_count", 32'(wf_cnt), 32'($countones(m_b)));
          check("add_used", 32'(add_seen), 32'(m_b != 16'd0));
        end
      end
    end
  end

  // Called at a negedge while the DUT is idle; returns at a negedge while idle.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input int restart_cyc, input int reset_cyc,
                       input int exp_cyc, input logic [31:0] exp_prod,
                       input string name);
    int got = 0;
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    for (int c = 1; c <= 60 && got == 0; c++) begin
      @(negedge clk);
      if (bus.done) got = c;
      bus.start = (c == restart_cyc);
      if (c == restart_cyc) begin
        bus.multiplicand = 16'd7;
        bus.multiplier   = 16'd7;
      end else begin
        bus.multiplicand = 16'($urandom);
        bus.multiplier   = 16'($urandom);
      end
      rst_n = (c != reset_cyc);
    end
    check({name, "_done_cycle"}, 32'(got), 32'(exp_cyc));
    check({name, "_product"}, bus.product, exp_prod);
    @(negedge clk);
    bus.start = 1'b0;
    rst_n     = 1'b1;
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.start        = 1'b1;
    bus.multiplicand = 16'h1111;
    bus.multiplier   = 16'h2222;
    @(posedge clk);
    cmp_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_product", bus.product, 32'd0);
    check("rst_funsel", 32'(bus.alu_funsel), 32'(5'b10000));
    check("rst_wf", 32'(bus.alu_wf), 32'd0);
    rst_n = 1'b1;

    do_op(16'd3,      16'd5,      0,  0, 10, 32'h0000_000F, "mul3x5");
    do_op(16'h1234,   16'd0,      0,  0, 2,  32'h0000_0000, "mul_zero");
    do_op(16'hFFFF,   16'hFFFF,   0,  0, 50, 32'hFFFE_0001, "mul_max");
    do_op(16'd2,      16'd3,      3,  0, 8,  32'h0000_0006, "start_busy");
    do_op(16'd6,      16'd9,      12, 0, 12, 32'h0000_0036, "start_in_done");
    do_op(16'h00FF,   16'h00FF,   0,  6, 0,  32'h0000_0000, "reset_mid");
    do_op(16'd4,      16'd4,      0,  0, 9,  32'h0000_0010, "mul4x4");

    for (int i = 0; i < 40; i++) begin
      logic [15:0] a, b;
      int lat;
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 16'($urandom_range(0, 15));
        1:       b = 16'($urandom);
        2:       b = 16'(1) << $urandom_range(0, 15);
        default: b = 16'hFFFF;
      endcase
      lat = lat_of(b);
      do_op(a, b, ($urandom_range(0, 1) == 1) ? $urandom_range(1, lat - 1) : 0, 0,
            lat, 32'(a) * 32'(b), "rand");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
